// File: rtl/brch_ckpt_fifo.sv
// Branch checkpoint FIFO: one {AL index, free-list pos} entry per in-flight branch, program order.
// Latency: insert visible to commit/mispredict search next cycle; rcvr_* and ckpt_err registered, 1 cycle.
// Backpressure: brch_stall (combinational) rejects a whole dispatch group that exceeds free entries.
module brch_ckpt_fifo #(
    parameter int DEPTH = 2,
    parameter int PTR_W = 1,
    parameter int IDX_W = 6,
    parameter int POS_W = 7
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 dispatch_en,
    input  logic [3:0]           brch_vld,
    input  logic [IDX_W-1:0]     nxt_indx,
    input  logic [4*POS_W-1:0]   alloc_pos,
    input  logic                 cmt_brch,
    input  logic [IDX_W-1:0]     cmt_brch_indx,
    input  logic                 mis_pred,
    input  logic [IDX_W-1:0]     brch_mis_indx,
    output logic [1:0]           brnc_count,
    output logic                 brch_stall,
    output logic [PTR_W-1:0]     head,
    output logic [PTR_W-1:0]     tail,
    output logic [PTR_W:0]       occ,
    output logic                 rcvr_vld,
    output logic [POS_W-1:0]     rcvr_pos,
    output logic [IDX_W-1:0]     rcvr_indx,
    output logic                 ckpt_err
);
    localparam int OW = PTR_W + 1;
    localparam int CW = (OW > 3) ? OW : 3;

    typedef struct packed {
        logic [IDX_W-1:0] indx;
        logic [POS_W-1:0] pos;
    } entry_t;

    entry_t ent [DEPTH];

    logic [CW-1:0]    grp_cnt;
    logic [CW-1:0]    free_cnt;
    logic             do_ins;
    logic             cmt_hit;
    logic             mis_hit;
    logic [PTR_W-1:0] mis_off;
    logic [PTR_W-1:0] mis_slot;
    logic [PTR_W-1:0] head_nxt;
    logic [PTR_W-1:0] tail_nxt;
    logic [OW-1:0]    occ_nxt;
    logic [DEPTH-1:0] wr_en;
    entry_t           wr_dat [DEPTH];

    // Full group count is kept internally so a 4-branch group still stalls correctly.
    always_comb begin
        grp_cnt = '0;
        for (int i = 0; i < 4; i++) begin
            grp_cnt = grp_cnt + CW'(brch_vld[i]);
        end
        if (!dispatch_en) begin
            grp_cnt = '0;
        end
    end

    assign brnc_count = grp_cnt[1:0];
    assign free_cnt   = CW'(DEPTH) - CW'(occ);
    assign brch_stall = dispatch_en & (grp_cnt > free_cnt);
    assign do_ins     = dispatch_en & ~brch_stall & ~mis_pred;

    always_comb begin
        logic [CW-1:0]    rank;
        logic [PTR_W-1:0] slot;
        rank  = '0;
        slot  = '0;
        wr_en = '0;
        for (int d = 0; d < DEPTH; d++) begin
            wr_dat[d] = '0;
        end
        for (int i = 0; i < 4; i++) begin
            if (brch_vld[i]) begin
                slot = tail + PTR_W'(rank);
                if (do_ins && (rank < CW'(DEPTH))) begin
                    wr_en[slot]       = 1'b1;
                    wr_dat[slot].indx = nxt_indx + IDX_W'(i);
                    wr_dat[slot].pos  = alloc_pos[i*POS_W +: POS_W];
                end
                rank = rank + CW'(1);
            end
        end
    end

    assign cmt_hit = cmt_brch & (occ != '0) & (ent[head].indx == cmt_brch_indx);

    // Scan youngest to oldest so the oldest matching entry is the one kept.
    always_comb begin
        logic [PTR_W-1:0] sl;
        sl       = '0;
        mis_hit  = 1'b0;
        mis_off  = '0;
        mis_slot = '0;
        for (int j = DEPTH - 1; j >= 0; j--) begin
            sl = head + PTR_W'(j);
            if ((OW'(j) < occ) && (ent[sl].indx == brch_mis_indx)) begin
                mis_hit  = 1'b1;
                mis_off  = PTR_W'(j);
                mis_slot = sl;
            end
        end
    end

    // Truncation length is measured from the post-commit head, so a same-cycle pop shortens it by one.
    always_comb begin
        head_nxt = head + PTR_W'(cmt_hit);
        tail_nxt = tail;
        occ_nxt  = occ;
        if (mis_pred && mis_hit) begin
            tail_nxt = mis_slot + PTR_W'(1);
            occ_nxt  = cmt_hit ? OW'(mis_off) : OW'(mis_off) + OW'(1);
        end else begin
            if (do_ins) begin
                tail_nxt = tail + PTR_W'(grp_cnt);
            end
            occ_nxt = occ - OW'(cmt_hit) + (do_ins ? OW'(grp_cnt) : OW'(0));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head      <= '0;
            tail      <= '0;
            occ       <= '0;
            rcvr_vld  <= 1'b0;
            rcvr_pos  <= '0;
            rcvr_indx <= '0;
            ckpt_err  <= 1'b0;
            for (int d = 0; d < DEPTH; d++) begin
                ent[d] <= '0;
            end
        end else begin
            head     <= head_nxt;
            tail     <= tail_nxt;
            occ      <= occ_nxt;
            rcvr_vld <= mis_pred & mis_hit;
            ckpt_err <= (cmt_brch & ~cmt_hit) | (mis_pred & ~mis_hit);
            if (mis_pred && mis_hit) begin
                rcvr_pos  <= ent[mis_slot].pos;
                rcvr_indx <= ent[mis_slot].indx;
            end
            for (int d = 0; d < DEPTH; d++) begin
                if (wr_en[d]) begin
                    ent[d] <= wr_dat[d];
                end
            end
        end
    end
endmodule

// File: tb/tb_brch_ckpt_fifo.sv
// Bench for brch_ckpt_fifo: queue-based reference model feeds a per-cycle scoreboard.
module tb_brch_ckpt_fifo;
    localparam int DEPTH = 2;
    localparam int PTR_W = 1;
    localparam int IDX_W = 6;
    localparam int POS_W = 7;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 dispatch_en;
    logic [3:0]           brch_vld;
    logic [IDX_W-1:0]     nxt_indx;
    logic [4*POS_W-1:0]   alloc_pos;
    logic                 cmt_brch;
    logic [IDX_W-1:0]     cmt_brch_indx;
    logic                 mis_pred;
    logic [IDX_W-1:0]     brch_mis_indx;
    logic [1:0]           brnc_count;
    logic                 brch_stall;
    logic [PTR_W-1:0]     head;
    logic [PTR_W-1:0]     tail;
    logic [PTR_W:0]       occ;
    logic                 rcvr_vld;
    logic [POS_W-1:0]     rcvr_pos;
    logic [IDX_W-1:0]     rcvr_indx;
    logic                 ckpt_err;

    brch_ckpt_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W), .IDX_W(IDX_W), .POS_W(POS_W)) dut (
        .clk(clk), .rst_n(rst_n), .dispatch_en(dispatch_en), .brch_vld(brch_vld),
        .nxt_indx(nxt_indx), .alloc_pos(alloc_pos), .cmt_brch(cmt_brch),
        .cmt_brch_indx(cmt_brch_indx), .mis_pred(mis_pred), .brch_mis_indx(brch_mis_indx),
        .brnc_count(brnc_count), .brch_stall(brch_stall), .head(head), .tail(tail),
        .occ(occ), .rcvr_vld(rcvr_vld), .rcvr_pos(rcvr_pos), .rcvr_indx(rcvr_indx),
        .ckpt_err(ckpt_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int indx;
        int pos;
    } ment_t;

    typedef struct {
        bit rv;
        int rp;
        int ri;
        bit err;
        int hd;
        int tl;
        int oc;
    } rec_t;

    ment_t mq[$];
    rec_t  sb[$];
    int    m_head  = 0;
    int    m_rpos  = 0;
    int    m_rindx = 0;
    int    checks   = 0;
    int    failures = 0;

    function automatic void chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // One call = one clock cycle: drive at negedge, check combinational outputs, advance the model.
    task automatic cyc(input bit rn, input bit de, input logic [3:0] bv, input int ni,
                       input logic [27:0] ap, input bit cb, input int ci,
                       input bit mp, input int mi);
        int   cnt;
        int   k;
        bit   stall;
        bit   ins;
        bit   cok;
        rec_t r;
        @(negedge clk);
        rst_n         = rn;
        dispatch_en   = de;
        brch_vld      = bv;
        nxt_indx      = IDX_W'(ni);
        alloc_pos     = ap;
        cmt_brch      = cb;
        cmt_brch_indx = IDX_W'(ci);
        mis_pred      = mp;
        brch_mis_indx = IDX_W'(mi);
        cnt   = de ? $countones(bv) : 0;
        stall = de && (cnt > DEPTH - mq.size());
        #1;
        if (cnt < 4) chk("brnc_count", int'(brnc_count), cnt);
        chk("brch_stall", int'(brch_stall), int'(stall));
        r = '{0, 0, 0, 0, 0, 0, 0};
        if (!rn) begin
            mq.delete();
            m_head  = 0;
            m_rpos  = 0;
            m_rindx = 0;
        end else begin
            ins = de && !stall && !mp;
            k = -1;
            for (int j = 0; j < mq.size(); j++) begin
                if (k < 0 && mq[j].indx == mi) k = j;
            end
            cok   = cb && (mq.size() > 0) && (mq[0].indx == ci);
            r.err = (cb && !cok) || (mp && k < 0);
            r.rv  = mp && (k >= 0);
            if (r.rv) begin
                m_rpos  = mq[k].pos;
                m_rindx = mq[k].indx;
                while (mq.size() > k + 1) void'(mq.pop_back());
            end
            if (cok) begin
                void'(mq.pop_front());
                m_head = (m_head + 1) % DEPTH;
            end
            if (ins) begin
                for (int i = 0; i < 4; i++) begin
                    if (bv[i]) mq.push_back('{(ni + i) % 64, int'(ap[i*POS_W +: POS_W])});
                end
            end
            r.rp = m_rpos;
            r.ri = m_rindx;
            r.hd = m_head;
            r.oc = mq.size();
            r.tl = (m_head + mq.size()) % DEPTH;
        end
        sb.push_back(r);
    endtask

    // Monitor: each cycle's expected outcome is popped and compared after the posedge.
    initial begin
        rec_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("rcvr_vld", int'(rcvr_vld), int'(e.rv));
                chk("rcvr_pos", int'(rcvr_pos), e.rp);
                chk("rcvr_indx", int'(rcvr_indx), e.ri);
                chk("ckpt_err", int'(ckpt_err), int'(e.err));
                chk("head", int'(head), e.hd);
                chk("tail", int'(tail), e.tl);
                chk("occ", int'(occ), e.oc);
            end
        end
    end

    initial begin
        logic [27:0] ap1;
        logic [3:0]  bv;
        logic [27:0] ap;
        int          nidx;
        int          ci;
        int          mi;
        bit          de;
        bit          cb;
        bit          mp;
        bit          rn;

        rst_n = 1'b0; dispatch_en = 1'b0; brch_vld = '0; nxt_indx = '0; alloc_pos = '0;
        cmt_brch = 1'b0; cmt_brch_indx = '0; mis_pred = 1'b0; brch_mis_indx = '0;
        ap1 = {7'h00, 7'h23, 7'h00, 7'h21};

        cyc(0, 0, 4'b0000, 0, '0, 0, 0, 0, 0);
        cyc(0, 0, 4'b0000, 0, '0, 0, 0, 0, 0);
        // Two-branch group fills the FIFO, then a single branch must stall
        cyc(1, 1, 4'b0101, 10, ap1, 0, 0, 0, 0);
        cyc(1, 1, 4'b0001, 14, 28'h1234567, 0, 0, 0, 0);
        cyc(1, 0, 4'b0000, 0, '0, 0, 0, 1, 10);
        cyc(1, 0, 4'b0000, 0, '0, 0, 0, 0, 0);
        // Commit oldest and mispredict the younger together
        cyc(0, 0, 4'b0000, 0, '0, 0, 0, 0, 0);
        cyc(1, 1, 4'b0101, 10, ap1, 0, 0, 0, 0);
        cyc(1, 0, 4'b0000, 0, '0, 1, 10, 1, 12);
        cyc(1, 0, 4'b0000, 0, '0, 1, 33, 0, 0);
        cyc(1, 0, 4'b0000, 0, '0, 0, 0, 0, 0);
        for (int p = 0; p < 6; p++) begin
            cb = mq.size() > 0;
            ci = cb ? mq[0].indx : 33;
            cyc(1, 1, 4'b0001 << (p % 3), 62, 28'($urandom), cb, ci, 0, 0);
        end
        mi = (mq.size() > 0) ? mq[0].indx : 0;
        cyc(0, 0, 4'b0000, 0, '0, 0, 0, 1, mi);
        cyc(1, 0, 4'b0000, 0, '0, 0, 0, 0, 0);

        nidx = 20;
        for (int n = 0; n < 3000; n++) begin
            de = $urandom_range(0, 2) != 0;
            bv = 4'($urandom);
            ap = 28'($urandom);
            cb = $urandom_range(0, 99) < 35;
            ci = (mq.size() > 0 && $urandom_range(0, 9) != 0) ? mq[0].indx : int'($urandom_range(0, 63));
            mp = $urandom_range(0, 99) < 15;
            mi = (mq.size() > 0 && $urandom_range(0, 4) != 0) ?
                 mq[$urandom_range(0, mq.size() - 1)].indx : int'($urandom_range(0, 63));
            rn = $urandom_range(0, 199) != 0;
            cyc(rn, de, bv, nidx, ap, cb, ci, mp, mi);
            nidx = (nidx + 4) % 64;
        end

        @(posedge clk);
        #2;
        chk("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
